// File: rtl/burst_envelope_pkg.sv
// Shared definitions for the burst envelope generator: state encoding and
// the gain/sample constants used by the envelope FSM and scaling pipeline.
package burst_envelope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam logic [7:0] ENV_MAX  = 8'd255;

endpackage

// File: rtl/env_prescaler.sv
// Step-rate prescaler: counts clocks and emits a one-cycle tick whenever the
// count has reached the (live) selected rate. A rate of 0 ticks every clock.
module env_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] count;

  // >= rather than == so that lowering the rate mid-count fires at once
  assign tick = (count >= rate);

  // Count up, restarting on each tick or on an external clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + RATE_W'(1);
    end
  end

endmodule

// File: rtl/burst_envelope.sv
// Attack/hold/release amplitude envelope for the chirp NCO. A trigger starts
// (or, from RELEASE, restarts) a burst; the 8-bit gain scales the
// offset-binary sample through a 2-stage multiply/offset pipeline.
module burst_envelope
  import burst_envelope_pkg::*;
#(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [7:0]        sample_in,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [RATE_W-1:0] hold_len,
  output logic [7:0]        sample_out,
  output logic [7:0]        env,
  output logic              busy
);

  env_state_t        state;
  logic [RATE_W-1:0] hold_cnt;
  logic [RATE_W-1:0] hold_next;
  logic [RATE_W-1:0] rate_sel;
  logic              tick;
  logic              go_attack;
  logic              attack_done;
  logic              hold_done;
  logic              release_done;
  logic              state_change;
  logic signed [8:0]  centered;
  logic signed [8:0]  gain;
  logic signed [17:0] prod_p1;
  logic               unused_prod_bits;

  assign rate_sel  = (state == ATTACK) ? attack_rate : release_rate;
  assign hold_next = hold_cnt + RATE_W'(1);

  // Transition qualifiers; any of them also restarts the prescaler so every
  // state begins with a full step period. A tick at 255 (re-entry from
  // RELEASE before the first decrement) still moves on to HOLD.
  assign go_attack    = trigger && ((state == IDLE) || (state == RELEASE));
  assign attack_done  = (state == ATTACK) && tick && (env >= ENV_MAX - 8'd1);
  assign hold_done    = (state == HOLD) && !trigger &&
                        ((hold_cnt == hold_len) || (tick && (hold_next == hold_len)));
  assign release_done = (state == RELEASE) && !trigger && tick && (env <= 8'd1);
  assign state_change = go_attack | attack_done | hold_done | release_done;

  env_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_change),
    .rate  (rate_sel),
    .tick  (tick)
  );

  // Envelope FSM with gain, hold counter and busy flag updated alongside state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      env      <= 8'd0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go_attack) begin
            state <= ATTACK;
            busy  <= 1'b1;
          end
        end
        ATTACK: begin
          if (tick) begin
            if (env != ENV_MAX) env <= env + 8'd1;
            if (attack_done) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (trigger) begin
            hold_cnt <= '0;
          end else if (hold_done) begin
            state <= RELEASE;
          end else if (tick) begin
            hold_cnt <= hold_next;
          end
        end
        RELEASE: begin
          // Retrigger keeps the current gain so the restart is seamless
          if (go_attack) begin
            state <= ATTACK;
          end else if (tick) begin
            if (env != 8'd0) env <= env - 8'd1;
            if (release_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign centered = $signed({1'b0, sample_in}) - 9'sd128;
  assign gain     = $signed({1'b0, env});

  // Stage 1: signed 9x9 product of centred sample and gain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_p1 <= '0;
    end else begin
      prod_p1 <= centered * gain;
    end
  end

  // Bits [15:8] are the low byte of prod >>> 8; the floored quotient always
  // fits in -128..126, so the high and fractional bits are not needed
  assign unused_prod_bits = ^{prod_p1[17:16], prod_p1[7:0]};

  // Stage 2: re-centre the scaled value around midscale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out <= MIDSCALE;
    end else begin
      sample_out <= MIDSCALE + prod_p1[15:8];
    end
  end

endmodule

// File: tb/tb_burst_envelope.sv
// Directed bench for burst_envelope: reset behaviour, attack/hold/release
// timing, retrigger, asynchronous mid-burst reset and the scaling pipeline.
module tb_burst_envelope;

  localparam int RATE_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              trigger;
  logic [7:0]        sample_in;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] release_rate;
  logic [RATE_W-1:0] hold_len;
  logic [7:0]        sample_out;
  logic [7:0]        env;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] s;
    logic [7:0] exp_full;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  burst_envelope #(.RATE_W(RATE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .trigger      (trigger),
    .sample_in    (sample_in),
    .attack_rate  (attack_rate),
    .release_rate (release_rate),
    .hold_len     (hold_len),
    .sample_out   (sample_out),
    .env          (env),
    .busy         (busy)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Poll on falling edges until env equals target; a timeout is a failure
  task automatic wait_env(input logic [7:0] target, input int bound);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (env == target) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL wait_env: env %0d never reached %0d", env, target);
    end
  endtask

  initial begin
    int e;

    // sample_in -> expected sample_out at env = 255 (floor of (s-128)*255/256 + 128)
    vecs[0] = '{8'd255, 8'd254};
    vecs[1] = '{8'd0,   8'd0};
    vecs[2] = '{8'd128, 8'd128};
    vecs[3] = '{8'd129, 8'd128};
    vecs[4] = '{8'd127, 8'd127};
    vecs[5] = '{8'd200, 8'd199};
    vecs[6] = '{8'd50,  8'd50};
    vecs[7] = '{8'd1,   8'd1};
    vecs[8] = '{8'd254, 8'd253};

    reset        = 1'b1;
    trigger      = 1'b0;
    sample_in    = 8'd200;
    attack_rate  = '0;
    release_rate = '0;
    hold_len     = 16'hFFFF;

    // Reset held with a non-midscale input
    repeat (3) begin
      @(negedge clk);
      chk8("rst_out", sample_out, 8'd128);
      chk8("rst_env", env, 8'd0);
      chk1("rst_busy", busy, 1'b0);
    end

    // Trigger in the first clock after release, attack_rate 0, full-scale input
    sample_in = 8'd255;
    reset     = 1'b0;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk1("att_busy", busy, 1'b1);
    chk8("att_env0", env, 8'd0);
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      chk8("att_ramp", env, 8'(k));
    end
    chk1("hold_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    chk8("full_out", sample_out, 8'd254);

    // Scaling table at env = 255 (HOLD with a very long hold_len)
    foreach (vecs[i]) begin
      sample_in = vecs[i].s;
      repeat (2) @(negedge clk);
      chk8("tbl_full", sample_out, vecs[i].exp_full);
      chk8("tbl_env", env, 8'd255);
    end

    // Hold length and release timing: hold_len 4, release_rate 1
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk8("rst2_env", env, 8'd0);
    hold_len     = 16'd4;
    release_rate = 16'd1;
    sample_in    = 8'd128;
    @(negedge clk);
    reset   = 1'b0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk8("b2_env0", env, 8'd0);
    repeat (255) @(negedge clk);
    chk8("b2_env255", env, 8'd255);
    for (int k = 1; k <= 522; k++) begin
      @(negedge clk);
      if (k < 8) e = 255;
      else e = 255 - (k - 8) / 2;
      if (e < 0) e = 0;
      chk8("hold_rel_env", env, 8'(e));
      chk1("hold_rel_busy", busy, (k < 518) ? 1'b1 : 1'b0);
    end

    // hold_len 0 and retrigger during RELEASE at env = 100
    hold_len     = '0;
    release_rate = '0;
    trigger      = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk8("b3_env0", env, 8'd0);
    repeat (255) @(negedge clk);
    chk8("b3_env255", env, 8'd255);
    @(negedge clk);
    chk8("b3_hold0", env, 8'd255);
    @(negedge clk);
    chk8("b3_rel1", env, 8'd254);
    wait_env(8'd100, 400);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk8("retrig_100", env, 8'd100);
    chk1("retrig_busy", busy, 1'b1);
    @(negedge clk);
    chk8("retrig_101", env, 8'd101);
    @(negedge clk);
    chk8("retrig_102", env, 8'd102);

    // Asynchronous reset between edges in ATTACK at env = 50
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    sample_in = 8'd200;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_env(8'd50, 100);
    #2;
    reset = 1'b1;
    #1;
    chk8("async_env", env, 8'd0);
    chk8("async_out", sample_out, 8'd128);
    chk1("async_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk8("post_rst_env", env, 8'd0);
      chk1("post_rst_busy", busy, 1'b0);
    end

    // Scaling table at env = 0: everything maps to midscale
    foreach (vecs[i]) begin
      sample_in = vecs[i].s;
      repeat (2) @(negedge clk);
      chk8("tbl_zero", sample_out, 8'd128);
    end

    // Trigger held every clock through ATTACK (rate 1) and HOLD (hold_len 3)
    attack_rate  = 16'd1;
    release_rate = '0;
    hold_len     = 16'd3;
    trigger      = 1'b1;
    @(negedge clk);
    chk8("ct_env0", env, 8'd0);
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      chk8("ct_attack", env, 8'(k / 2));
    end
    repeat (40) begin
      @(negedge clk);
      chk8("ct_hold_env", env, 8'd255);
      chk1("ct_hold_busy", busy, 1'b1);
    end
    trigger = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk8("ct_exit_wait", env, 8'd255);
    end
    @(negedge clk);
    chk8("ct_rel_first", env, 8'd254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
